perceptron_trainer: RTL and testbench

- Parametrised successor to the fixed 2-input, 14-bit perceptron training unit.
- Trains an N_IN-input perceptron (bipolar targets, signed fixed-point weights and bias) over epochs of samples streamed by a host over a valid/ready handshake.
- Stops on the first error-free epoch (converged) or when MAX_EPOCH is reached; learning rate is a configurable right shift.
- Sits beside the sample memory/host sequencer; final weights are held on outputs.

---
 rtl/perceptron_trainer_if.sv | 14 +
 rtl/perceptron_trainer.sv | 172 +++++++++++++++++
 tb/tb_perceptron_trainer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_trainer_if.sv
// rtl/perceptron_trainer_if.sv - sample stream handshake between host sequencer and trainer
interface perceptron_trainer_if #(
   parameter int N_IN = 2,
   parameter int DW   = 14
);
   logic [N_IN*DW-1:0] s_x;
   logic               s_t;
   logic               s_last;
   logic               s_valid;
   logic               s_ready;

   modport master (output s_x, s_t, s_last, s_valid, input s_ready);
   modport slave  (input s_x, s_t, s_last, s_valid, output s_ready);
endinterface

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - N_IN-input perceptron trainer, epochs streamed by host, stops on
// the first error-free epoch or at MAX_EPOCH
module perceptron_trainer #(
   parameter int N_IN      = 2,
   parameter int DW        = 14,
   parameter int FRAC      = 8,
   parameter int LR_SHIFT  = 0,
   parameter int MAX_EPOCH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   perceptron_trainer_if.slave            s,
   output logic                           epoch_req,
   output logic [N_IN*DW-1:0]             w_out,
   output logic [DW-1:0]                  b_out,
   output logic [$clog2(MAX_EPOCH+1)-1:0] epoch_cnt,
   output logic                           busy,
   output logic                           done,
   output logic                           converged
);
   localparam int EW = $clog2(MAX_EPOCH + 1);
   localparam int AW = 2*DW + $clog2(N_IN + 1) + 1;
   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [EW:0]          MAXE = (EW+1)'(MAX_EPOCH);
   localparam logic signed [DW+1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
   localparam logic signed [DW+1:0] SMIN = {3'b111, {(DW-1){1'b0}}};
   localparam logic signed [DW:0]   ONE  = {{DW{1'b0}}, 1'b1} << FRAC;

   typedef enum logic [2:0] {IDLE, INIT, WAIT_S, MAC, EVAL, UPD, EPOCH_END, DONE} state_t;

   state_t                 state;
   logic signed [DW-1:0]   w     [N_IN];
   logic signed [DW-1:0]   xr    [N_IN];
   logic signed [DW-1:0]   w_nxt [N_IN];
   logic signed [DW:0]     xe    [N_IN];
   logic signed [DW:0]     de    [N_IN];
   logic signed [DW:0]     ds    [N_IN];
   logic signed [DW+1:0]   sum   [N_IN];
   logic signed [DW-1:0]   b, b_nxt;
   logic signed [DW:0]     bd, bs;
   logic signed [DW+1:0]   bsum;
   logic signed [AW-1:0]   acc, acc_init, prod_ext;
   logic signed [2*DW-1:0] mx, mw, prod;
   logic [IW-1:0]          idx;
   logic [7:0]             mis;
   logic                   tr, lastr, ready;
   logic [EW:0]            ep_next;

   function automatic logic signed [DW-1:0] sat(input logic signed [DW+1:0] v);
      if (v > SMAX)      return SMAX[DW-1:0];
      else if (v < SMIN) return SMIN[DW-1:0];
      else               return v[DW-1:0];
   endfunction

   always_comb begin
      mx       = {{DW{xr[idx][DW-1]}}, xr[idx]};
      mw       = {{DW{w[idx][DW-1]}}, w[idx]};
      prod     = mx * mw;
      prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
      acc_init = {{(AW-DW){b[DW-1]}}, b} << FRAC;
      ep_next  = {1'b0, epoch_cnt} + 1'b1;
      // delta is formed one bit wider so negating the most negative input cannot wrap
      for (int i = 0; i < N_IN; i++) begin
         xe[i]    = {xr[i][DW-1], xr[i]};
         de[i]    = tr ? xe[i] : -xe[i];
         ds[i]    = de[i] >>> LR_SHIFT;
         sum[i]   = {ds[i][DW], ds[i]} + {{2{w[i][DW-1]}}, w[i]};
         w_nxt[i] = sat(sum[i]);
      end
      bd    = tr ? ONE : -ONE;
      bs    = bd >>> LR_SHIFT;
      bsum  = {bs[DW], bs} + {{2{b[DW-1]}}, b};
      b_nxt = sat(bsum);
      for (int i = 0; i < N_IN; i++) w_out[i*DW +: DW] = w[i];
   end

   assign b_out     = b;
   assign s.s_ready = ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         for (int i = 0; i < N_IN; i++) begin
            w[i]  <= '0;
            xr[i] <= '0;
         end
         b         <= '0;
         acc       <= '0;
         mis       <= '0;
         epoch_cnt <= '0;
         idx       <= '0;
         tr        <= 1'b0;
         lastr     <= 1'b0;
         ready     <= 1'b0;
         epoch_req <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         converged <= 1'b0;
      end else begin
         epoch_req <= 1'b0;
         case (state)
            IDLE, DONE: if (start) state <= INIT;
            INIT: begin
               for (int i = 0; i < N_IN; i++) w[i] <= '0;
               b         <= '0;
               epoch_cnt <= '0;
               mis       <= '0;
               done      <= 1'b0;
               converged <= 1'b0;
               busy      <= 1'b1;
               epoch_req <= 1'b1;
               ready     <= 1'b1;
               state     <= WAIT_S;
            end
            WAIT_S: if (s.s_valid && ready) begin
               for (int i = 0; i < N_IN; i++) xr[i] <= s.s_x[i*DW +: DW];
               tr    <= s.s_t;
               lastr <= s.s_last;
               acc   <= acc_init;
               idx   <= '0;
               ready <= 1'b0;
               state <= MAC;
            end
            MAC: begin
               acc <= acc + prod_ext;
               if (idx == IW'(N_IN - 1)) state <= EVAL;
               else                      idx   <= idx + 1'b1;
            end
            // sign bit equal to target means prediction and target disagree
            EVAL: if (acc[AW-1] == tr) begin
               if (mis != '1) mis <= mis + 1'b1;
               state <= UPD;
            end else if (lastr) begin
               state <= EPOCH_END;
            end else begin
               ready <= 1'b1;
               state <= WAIT_S;
            end
            UPD: begin
               for (int i = 0; i < N_IN; i++) w[i] <= w_nxt[i];
               b <= b_nxt;
               if (lastr) state <= EPOCH_END;
               else begin
                  ready <= 1'b1;
                  state <= WAIT_S;
               end
            end
            EPOCH_END: begin
               epoch_cnt <= ep_next[EW-1:0];
               if (mis == '0) begin
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  converged <= 1'b1;
                  state     <= DONE;
               end else if (ep_next == MAXE) begin
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  converged <= 1'b0;
                  state     <= DONE;
               end else begin
                  mis       <= '0;
                  epoch_req <= 1'b1;
                  ready     <= 1'b1;
                  state     <= WAIT_S;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - scenario table plus handshake/reset sequences for perceptron_trainer
module tb_perceptron_trainer;
   localparam int N  = 2;
   localparam int DW = 14;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0]      start_v;
   logic [N*DW-1:0] sx;
   logic            st, slast, svalid;
   logic [N*DW-1:0] wout [3];
   logic [DW-1:0]   bout [3];
   logic [2:0]      req, busy_v, done_v, conv_v;
   logic [4:0]      ec0, ec2;
   logic [2:0]      ec1;

   perceptron_trainer_if #(.N_IN(N), .DW(DW)) if0 ();
   perceptron_trainer_if #(.N_IN(N), .DW(DW)) if1 ();
   perceptron_trainer_if #(.N_IN(N), .DW(DW)) if2 ();
   assign if0.s_x = sx; assign if0.s_t = st; assign if0.s_last = slast; assign if0.s_valid = svalid;
   assign if1.s_x = sx; assign if1.s_t = st; assign if1.s_last = slast; assign if1.s_valid = svalid;
   assign if2.s_x = sx; assign if2.s_t = st; assign if2.s_last = slast; assign if2.s_valid = svalid;

   perceptron_trainer #(.N_IN(N), .DW(DW), .FRAC(8), .LR_SHIFT(0), .MAX_EPOCH(16)) dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .s(if0), .epoch_req(req[0]), .w_out(wout[0]),
      .b_out(bout[0]), .epoch_cnt(ec0), .busy(busy_v[0]), .done(done_v[0]), .converged(conv_v[0]));
   perceptron_trainer #(.N_IN(N), .DW(DW), .FRAC(8), .LR_SHIFT(0), .MAX_EPOCH(4)) dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .s(if1), .epoch_req(req[1]), .w_out(wout[1]),
      .b_out(bout[1]), .epoch_cnt(ec1), .busy(busy_v[1]), .done(done_v[1]), .converged(conv_v[1]));
   perceptron_trainer #(.N_IN(N), .DW(DW), .FRAC(8), .LR_SHIFT(1), .MAX_EPOCH(16)) dut2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .s(if2), .epoch_req(req[2]), .w_out(wout[2]),
      .b_out(bout[2]), .epoch_cnt(ec2), .busy(busy_v[2]), .done(done_v[2]), .converged(conv_v[2]));

   logic [1:0] sel;
   int   cur_w0, cur_w1, cur_b, cur_ec;
   logic cur_rdy, cur_req, cur_busy, cur_done, cur_conv;

   always_comb begin
      cur_w0   = int'($signed(wout[sel][DW-1:0]));
      cur_w1   = int'($signed(wout[sel][2*DW-1:DW]));
      cur_b    = int'($signed(bout[sel]));
      cur_ec   = (sel == 2'd0) ? int'(ec0) : (sel == 2'd1) ? int'(ec1) : int'(ec2);
      cur_rdy  = (sel == 2'd0) ? if0.s_ready : (sel == 2'd1) ? if1.s_ready : if2.s_ready;
      cur_req  = req[sel];
      cur_busy = busy_v[sel];
      cur_done = done_v[sel];
      cur_conv = conv_v[sel];
   end

   typedef struct {
      int dut; int ds; int lr; int ep; int conv; int w0; int w1; int b; int nreq;
   } scn_t;
   scn_t tbl [4];
   int   dx0 [3][4];
   int   dx1 [3][4];
   int   dt  [3][4];
   int   dn  [3];

   int n_chk = 0;
   int n_err = 0;
   int sb [$];
   int mw0, mw1, mb, mlr;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int msat(input int v);
      if (v > 8191)  return 8191;
      if (v < -8192) return -8192;
      return v;
   endfunction

   // reference perceptron: integer arithmetic on the real-valued rule scaled by 256
   task automatic model_step(input int x0, input int x1, input int t, output int m);
      int acc, sg;
      acc = x0*mw0 + x1*mw1 + mb*256;
      m   = ((acc >= 0) != (t == 1)) ? 1 : 0;
      if (m == 1) begin
         sg  = (t == 1) ? 1 : -1;
         mw0 = msat(mw0 + ((sg*x0) >>> mlr));
         mw1 = msat(mw1 + ((sg*x1) >>> mlr));
         mb  = msat(mb  + ((sg*256) >>> mlr));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_v[sel] = 1'b1;
      tick();
      start_v = '0;
   endtask

   task automatic wait_req(output bit got);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         tick();
         got = cur_req;
      end
   endtask

   task automatic send_sample(input int d, input int k, input bit abort);
      int  m, lat, expv;
      bit  last;
      last   = (k == dn[d] - 1);
      sx     = {14'(dx1[d][k]), 14'(dx0[d][k])};
      st     = (dt[d][k] == 1);
      slast  = last;
      svalid = 1'b1;
      for (int c = 0; c < 30 && !cur_rdy; c++) tick();
      if (!cur_rdy) begin
         chk("ready_timeout", 0, 1);
         svalid = 1'b0;
         return;
      end
      tick();
      svalid = 1'b0;
      if (abort) return;
      model_step(dx0[d][k], dx1[d][k], dt[d][k], m);
      sb.push_back(N + 1 + m + (last ? 1 : 0));
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!(cur_rdy || cur_done) && lat < 30);
      expv = sb.pop_front();
      chk(last ? "latency_last" : "latency", lat, expv);
   endtask

   task automatic run_scn(input scn_t s, input bit stall);
      bit got, fin;
      int nreq, ec_hold;
      sel = 2'(s.dut);
      mlr = s.lr; mw0 = 0; mw1 = 0; mb = 0;
      pulse_start();
      wait_req(got);
      chk("init_req", int'(got), 1);
      if (!got) return;
      nreq = 1;
      chk("busy", int'(cur_busy), 1);
      if (stall) begin
         for (int c = 0; c < 5; c++) begin
            if (c == 1) start_v[sel] = 1'b1;
            tick();
            start_v = '0;
            chk("stall_ready", int'(cur_rdy), 1);
            chk("stall_no_req", int'(cur_req), 0);
         end
         chk("stall_epoch", cur_ec, 0);
      end
      fin = 1'b0;
      for (int g = 0; g < 20 && !fin; g++) begin
         for (int k = 0; k < dn[s.ds]; k++) send_sample(s.ds, k, 1'b0);
         if (cur_done) fin = 1'b1;
         else if (cur_req) nreq++;
         else begin
            chk("epoch_boundary", 0, 1);
            fin = 1'b1;
         end
      end
      chk("done", int'(cur_done), 1);
      chk("busy_low", int'(cur_busy), 0);
      chk("converged", int'(cur_conv), s.conv);
      chk("epoch_cnt", cur_ec, s.ep);
      chk("epoch_req_count", nreq, s.nreq);
      chk("w0", cur_w0, s.w0);
      chk("w1", cur_w1, s.w1);
      chk("b", cur_b, s.b);
      chk("w0_model", cur_w0, mw0);
      chk("b_model", cur_b, mb);
      ec_hold = cur_ec;
      svalid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("no_ready_after_done", int'(cur_rdy), 0);
      end
      svalid = 1'b0;
      chk("epoch_cnt_frozen", cur_ec, ec_hold);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      bit got;
      tbl[0] = '{dut:0, ds:0, lr:0, ep:3, conv:1, w0:256,  w1:256, b:-256, nreq:3};
      tbl[1] = '{dut:0, ds:1, lr:0, ep:2, conv:1, w0:8191, w1:0,   b:-256, nreq:2};
      tbl[2] = '{dut:1, ds:2, lr:0, ep:4, conv:0, w0:-256, w1:0,   b:-256, nreq:4};
      tbl[3] = '{dut:2, ds:0, lr:1, ep:3, conv:1, w0:128,  w1:128, b:-128, nreq:3};
      dx0[0] = '{256, 256, -256, -256}; dx1[0] = '{256, -256, 256, -256}; dt[0] = '{1, 0, 0, 0}; dn[0] = 4;
      dx0[1] = '{-8192, 0, 0, 0};       dx1[1] = '{0, 0, 0, 0};           dt[1] = '{0, 0, 0, 0}; dn[1] = 1;
      dx0[2] = '{256, 256, 0, 0};       dx1[2] = '{0, 0, 0, 0};           dt[2] = '{1, 0, 0, 0}; dn[2] = 2;

      sel = 2'd0; start_v = '0; sx = '0; st = 1'b0; slast = 1'b0; svalid = 1'b0;
      rst = 1'b1;
      tick(); tick();
      chk("rst_busy", int'(cur_busy), 0);
      chk("rst_done", int'(cur_done), 0);
      chk("rst_ready", int'(cur_rdy), 0);
      chk("rst_req", int'(cur_req), 0);
      chk("rst_w0", cur_w0, 0);
      chk("rst_ec", cur_ec, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) run_scn(tbl[i], i == 0);

      // abandon the AND run mid-MAC of epoch 2 with an asynchronous reset
      sel = 2'd0; mlr = 0; mw0 = 0; mw1 = 0; mb = 0;
      pulse_start();
      wait_req(got);
      chk("rerun_req", int'(got), 1);
      for (int k = 0; k < 4; k++) send_sample(0, k, 1'b0);
      chk("epoch2_req", int'(cur_req), 1);
      chk("mid_b_before_rst", cur_b, -512);
      send_sample(0, 0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_b", cur_b, 0);
      chk("async_rst_w1", cur_w1, 0);
      chk("async_rst_ec", cur_ec, 0);
      chk("async_rst_busy", int'(cur_busy), 0);
      chk("async_rst_ready", int'(cur_rdy), 0);
      tick();
      rst = 1'b0;
      tick();
      run_scn(tbl[0], 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
